// File: rtl/perf_cnt_master.sv
// Avalon-MM master that drives the performance-counter slave on behalf of accelerator
// commands. Time reads use a high/low/high sequence so a running counter is never torn.
module perf_cnt_master #(
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_section,
    output logic        cmd_done,
    output logic [63:0] result_time,
    output logic [31:0] result_events,
    output logic        result_torn,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid
);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [1:0] OP_GO    = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_READ  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD_HI1, S_RD_LO, S_RD_HI2, S_RD_EV, S_DONE
    } state_t;

    state_t        r_state, w_next;
    logic          r_req;
    logic [1:0]    r_op;
    logic [2:0]    r_sec;
    logic [31:0]   r_hi1, r_lo;
    logic [63:0]   r_time;
    logic          r_torn;
    logic [RW-1:0] r_retry;
    logic [63:0]   r_result_time;
    logic [31:0]   r_result_events;
    logic          r_result_torn;

    logic          w_cmd_acc, w_accept, w_rd_state, w_rdv;
    logic          w_hi_match, w_retry_out, w_next_req;
    logic [4:0]    w_wr_addr;

    assign w_cmd_acc   = cmd_valid & cmd_ready;
    assign w_accept    = r_req & ~avm_waitrequest;
    assign w_rd_state  = r_state inside {S_RD_HI1, S_RD_LO, S_RD_HI2, S_RD_EV};
    // Data only counts once our own request has been accepted; stray beats are dropped.
    assign w_rdv       = w_rd_state & ~r_req & avm_readdatavalid;
    assign w_hi_match  = (avm_readdata == r_hi1);
    assign w_retry_out = (r_retry == RW'(MAX_RETRY));
    assign w_next_req  = w_next inside {S_WR, S_RD_HI1, S_RD_LO, S_RD_HI2, S_RD_EV};

    always_comb begin
        case (r_op)
            OP_GO:   w_wr_addr = {r_sec, 2'b01};
            OP_STOP: w_wr_addr = {r_sec, 2'b00};
            default: w_wr_addr = 5'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) r_req <= w_next_req;
            else if (w_accept)     r_req <= 1'b0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_cmd_acc) w_next = (cmd_op == OP_READ) ? S_RD_HI1 : S_WR;
            S_WR:     if (w_accept)  w_next = S_DONE;
            S_RD_HI1: if (w_rdv)     w_next = S_RD_LO;
            S_RD_LO:  if (w_rdv)     w_next = S_RD_HI2;
            S_RD_HI2: if (w_rdv)     w_next = (w_hi_match || w_retry_out) ? S_RD_EV : S_RD_LO;
            S_RD_EV:  if (w_rdv)     w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = (r_state == S_IDLE);
        cmd_done      = (r_state == S_DONE);
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_address   = 5'd0;
        avm_writedata = 32'd0;
        case (r_state)
            S_WR: begin
                avm_write     = r_req;
                avm_address   = w_wr_addr;
                avm_writedata = {31'd0, (r_op == OP_CLEAR)};
            end
            S_RD_HI1, S_RD_HI2: begin
                avm_read    = r_req;
                avm_address = {r_sec, 2'b01};
            end
            S_RD_LO: begin
                avm_read    = r_req;
                avm_address = {r_sec, 2'b00};
            end
            S_RD_EV: begin
                avm_read    = r_req;
                avm_address = {r_sec, 2'b10};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op            <= 2'd0;
            r_sec           <= 3'd0;
            r_hi1           <= 32'd0;
            r_lo            <= 32'd0;
            r_time          <= 64'd0;
            r_torn          <= 1'b0;
            r_retry         <= '0;
            r_result_time   <= 64'd0;
            r_result_events <= 32'd0;
            r_result_torn   <= 1'b0;
        end else begin
            if (w_cmd_acc) begin
                r_op    <= cmd_op;
                r_sec   <= cmd_section;
                r_retry <= '0;
                r_torn  <= 1'b0;
                if (cmd_op == OP_READ) r_result_torn <= 1'b0;
            end
            if (w_rdv) begin
                case (r_state)
                    S_RD_HI1: r_hi1 <= avm_readdata;
                    S_RD_LO:  r_lo  <= avm_readdata;
                    S_RD_HI2: begin
                        if (w_hi_match) begin
                            r_time <= {r_hi1, r_lo};
                        end else if (w_retry_out) begin
                            r_time <= {avm_readdata, r_lo};
                            r_torn <= 1'b1;
                        end else begin
                            r_hi1   <= avm_readdata;
                            r_retry <= r_retry + RW'(1);
                        end
                    end
                    // Results land on the edge into DONE so they are valid alongside cmd_done.
                    S_RD_EV: begin
                        r_result_time   <= r_time;
                        r_result_events <= avm_readdata;
                        r_result_torn   <= r_torn;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign result_time   = r_result_time;
    assign result_events = r_result_events;
    assign result_torn   = r_result_torn;
endmodule

// File: tb/tb_perf_cnt_master.sv
// Bench for perf_cnt_master: Avalon slave model, command scoreboard and result monitor.
module tb_perf_cnt_master;
    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_section;
    logic        cmd_done;
    logic [63:0] result_time;
    logic [31:0] result_events;
    logic        result_torn;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;

    perf_cnt_master #(.MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_section(cmd_section), .cmd_done(cmd_done),
        .result_time(result_time), .result_events(result_events), .result_torn(result_torn),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit wr; logic [4:0] addr; logic [31:0] data; } bus_t;
    typedef struct { logic [63:0] t; logic [31:0] ev; logic torn; int acc; int lat; } res_t;

    bus_t        exp_bus_q[$];
    res_t        exp_res_q[$];
    logic [31:0] rd_data_q[$];
    logic [4:0]  seen_addr[$];
    int          lat_q[$];

    logic [63:0] m_time = 64'd0;
    logic [31:0] m_ev = 32'd0;
    logic        m_torn = 1'b0;
    logic [31:0] g_h[0:MAX_RETRY+1];
    logic [31:0] g_l[0:MAX_RETRY];
    logic [31:0] g_ev;

    bit   stall_en = 1'b0;
    int   lat_max = 1;
    int   force_stall = -1;
    int   acc_cnt = 0;
    int   last_req_cycles = 0;
    bus_t last_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    task automatic push_bus(input bit wr, input int addr, input logic [31:0] data);
        bus_t b;
        b.wr = wr;
        b.addr = 5'(addr);
        b.data = data;
        exp_bus_q.push_back(b);
    endtask

    // Avalon slave: random or forced stalls, scripted read data, programmable latency.
    initial begin
        bit   req, wt, in_req, prev_stalled, prev_acc;
        int   stall_left, req_cycles, ret_cnt;
        logic [31:0] ret_val;
        bus_t cur, prev_b, e;
        in_req = 0; prev_stalled = 0; prev_acc = 0;
        stall_left = 0; req_cycles = 0; ret_cnt = 0; ret_val = 0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata = 32'd0;
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            if (ret_cnt > 0) begin
                ret_cnt--;
                if (ret_cnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = ret_val;
                end
            end
            req = avm_read | avm_write;
            cur.wr = avm_write;
            cur.addr = avm_address;
            cur.data = avm_writedata;
            if (avm_read && avm_write) flag("rd_wr_both_high");
            if (prev_stalled && (!req || cur.wr != prev_b.wr || cur.addr != prev_b.addr ||
                                 cur.data != prev_b.data)) flag("request_not_held");
            if (prev_acc && req) flag("request_not_dropped_after_accept");
            if (req && !in_req) begin
                in_req = 1;
                req_cycles = 0;
                if (force_stall >= 0) begin
                    stall_left = force_stall;
                    force_stall = -1;
                end else begin
                    stall_left = stall_en ? int'($urandom_range(0, 3)) : 0;
                end
            end
            if (req) begin
                req_cycles++;
                wt = (stall_left > 0);
                if (wt) stall_left--;
            end else begin
                wt = stall_en && ($urandom_range(0, 1) == 1);
            end
            avm_waitrequest = wt;
            prev_stalled = req && wt;
            prev_acc = req && !wt;
            prev_b = cur;
            if (req && !wt) begin
                in_req = 0;
                last_req_cycles = req_cycles;
                last_acc = cur;
                acc_cnt++;
                seen_addr.push_back(cur.addr);
                if (exp_bus_q.size() == 0) begin
                    flag("unexpected_bus_transfer");
                end else begin
                    e = exp_bus_q.pop_front();
                    chk("bus_kind_wr", 64'(cur.wr), 64'(e.wr));
                    chk("bus_addr", 64'(cur.addr), 64'(e.addr));
                    if (e.wr) chk("bus_wdata", 64'(cur.data), 64'(e.data));
                end
                if (!cur.wr) begin
                    if (rd_data_q.size() == 0) begin
                        flag("read_without_script");
                        ret_val = 32'd0;
                    end else begin
                        ret_val = rd_data_q.pop_front();
                    end
                    ret_cnt = (lat_q.size() > 0) ? lat_q.pop_front()
                                                 : int'($urandom_range(1, lat_max));
                end
            end
        end
    end

    // Result monitor: each cmd_done consumes one expected completion.
    initial begin
        res_t r;
        forever begin
            @(posedge clk);
            #1;
            if (cmd_done === 1'b1) begin
                if (exp_res_q.size() == 0) begin
                    flag("unexpected_cmd_done");
                end else begin
                    r = exp_res_q.pop_front();
                    chk("result_time", result_time, r.t);
                    chk("result_events", 64'(result_events), 64'(r.ev));
                    chk("result_torn", 64'(result_torn), 64'(r.torn));
                    if (r.lat > 0) chk("done_latency", 64'(cyc - r.acc), 64'(r.lat));
                end
            end
        end
    end

    task automatic gen_script(input int nm);
        g_h[0] = $urandom;
        for (int i = 0; i <= MAX_RETRY; i++) begin
            g_l[i] = $urandom;
            g_h[i+1] = (i < nm) ? (g_h[i] ^ 32'($urandom_range(1, 255))) : g_h[i];
        end
        g_ev = $urandom;
    endtask

    // Issues one command; once acceptance is certain, pushes the model's expectations.
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] sec, input int lat_exp);
        bit ok;
        int s4, acc;
        logic [31:0] hi1;
        res_t r;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_section = sec;
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            flag("cmd_accept_timeout");
            cmd_valid = 1'b0;
            return;
        end
        acc = cyc;
        s4 = 4 * int'(sec);
        if (op == 2'd3) begin
            m_torn = 1'b0;
            hi1 = g_h[0];
            push_bus(1'b0, s4 + 1, 32'd0);
            rd_data_q.push_back(g_h[0]);
            for (int i = 0; i <= MAX_RETRY; i++) begin
                push_bus(1'b0, s4, 32'd0);
                rd_data_q.push_back(g_l[i]);
                push_bus(1'b0, s4 + 1, 32'd0);
                rd_data_q.push_back(g_h[i+1]);
                if (g_h[i+1] == hi1) begin
                    m_time = {hi1, g_l[i]};
                    break;
                end
                if (i == MAX_RETRY) begin
                    m_time = {g_h[i+1], g_l[i]};
                    m_torn = 1'b1;
                    break;
                end
                hi1 = g_h[i+1];
            end
            push_bus(1'b0, s4 + 2, 32'd0);
            rd_data_q.push_back(g_ev);
            m_ev = g_ev;
        end else begin
            push_bus(1'b1, (op == 2'd0) ? s4 + 1 : (op == 2'd1) ? s4 : 0,
                     (op == 2'd2) ? 32'd1 : 32'd0);
        end
        r.t = m_time;
        r.ev = m_ev;
        r.torn = m_torn;
        r.acc = acc;
        r.lat = lat_exp;
        exp_res_q.push_back(r);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (cmd_ready && exp_res_q.size() == 0) return;
        end
        flag("wait_idle_timeout");
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_cmd_done"}, 64'(cmd_done), 64'd0);
        chk({tag, "_avm_read"}, 64'(avm_read), 64'd0);
        chk({tag, "_avm_write"}, 64'(avm_write), 64'd0);
        chk({tag, "_avm_address"}, 64'(avm_address), 64'd0);
        chk({tag, "_avm_writedata"}, 64'(avm_writedata), 64'd0);
        chk({tag, "_result_time"}, result_time, 64'd0);
        chk({tag, "_result_events"}, 64'(result_events), 64'd0);
        chk({tag, "_result_torn"}, 64'(result_torn), 64'd0);
    endtask

    initial begin
        int base;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
        cmd_section = 3'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        // GO on section 2
        seen_addr.delete();
        do_cmd(2'd0, 3'd2, 2);
        @(negedge clk);
        chk("go_busy_t1", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("go_done_t2", 64'(cmd_done), 64'd1);
        @(negedge clk);
        chk("go_ready_t3", 64'(cmd_ready), 64'd1);
        chk("go_transfers", 64'(seen_addr.size()), 64'd1);
        chk("go_is_write", 64'(last_acc.wr), 64'd1);
        chk("go_addr", 64'(last_acc.addr), 64'd9);
        chk("go_data", 64'(last_acc.data), 64'd0);

        // CLEAR_ALL ignores the section
        do_cmd(2'd2, 3'd5, 2);
        wait_idle();
        chk("clear_addr", 64'(last_acc.addr), 64'd0);
        chk("clear_data", 64'(last_acc.data), 64'd1);

        // STOP stalled for 3 cycles, with the next command held on cmd_valid
        force_stall = 3;
        do_cmd(2'd1, 3'd3, 5);
        cmd_valid = 1'b1;
        cmd_op = 2'd0;
        cmd_section = 3'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("backpressure_ready", 64'(cmd_ready), 64'd0);
        end
        chk("stall_req_cycles", 64'(last_req_cycles), 64'd4);
        do_cmd(2'd0, 3'd7, 2);
        wait_idle();

        // READ section 1, clean first pass
        g_h[0] = 32'h1; g_h[1] = 32'h1; g_l[0] = 32'hFFFF_FFF0; g_ev = 32'd7;
        seen_addr.delete();
        do_cmd(2'd3, 3'd1, 9);
        wait_idle();
        chk("rd1_time", result_time, 64'h1_FFFF_FFF0);
        chk("rd1_events", 64'(result_events), 64'd7);
        chk("rd1_torn", 64'(result_torn), 64'd0);
        chk("rd1_nreads", 64'(seen_addr.size()), 64'd4);

        // READ section 0 with one retry
        g_h[0] = 32'h0; g_l[0] = 32'hFFFF_FFFF; g_h[1] = 32'h1; g_l[1] = 32'h2; g_h[2] = 32'h1;
        g_ev = 32'h55;
        do_cmd(2'd3, 3'd0, 13);
        wait_idle();
        chk("rd_retry_time", result_time, 64'h1_0000_0002);
        chk("rd_retry_torn", 64'(result_torn), 64'd0);

        // READ where every compare mismatches: torn after MAX_RETRY retries
        for (int i = 0; i <= MAX_RETRY; i++) begin
            g_h[i] = 32'(i);
            g_l[i] = 32'hDEAD_0000 + 32'(i);
        end
        g_h[MAX_RETRY+1] = 32'(MAX_RETRY + 1);
        g_ev = 32'h99;
        seen_addr.delete();
        do_cmd(2'd3, 3'd6, 21);
        wait_idle();
        chk("rd_torn_time", result_time, 64'h4_DEAD_0003);
        chk("rd_torn_flag", 64'(result_torn), 64'd1);
        chk("rd_torn_nreads", 64'(seen_addr.size()), 64'd10);

        // Reset while RD_LO waits; its data then arrives after reset is released
        gen_script(0);
        lat_q.push_back(1);
        lat_q.push_back(6);
        base = acc_cnt;
        do_cmd(2'd3, 3'd3, 0);
        for (int k = 0; k < 200 && acc_cnt < base + 2; k++) begin
            @(posedge clk);
            #1;
        end
        chk("midreset_reached_rd_lo", 64'(acc_cnt), 64'(base + 2));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        exp_bus_q.delete();
        exp_res_q.delete();
        rd_data_q.delete();
        m_time = 64'd0; m_ev = 32'd0; m_torn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_reset_idle", 64'(cmd_ready), 64'd1);

        gen_script(1);
        do_cmd(2'd3, 3'd4, 13);
        wait_idle();
        chk("post_reset_read_time", result_time, {g_h[1], g_l[1]});

        // Randomised traffic with stalls and variable read latency
        stall_en = 1'b1;
        lat_max = 3;
        for (int n = 0; n < 40; n++) begin
            gen_script(int'($urandom_range(0, MAX_RETRY + 1)));
            do_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 0);
        end
        wait_idle();
        chk("bus_queue_drained", 64'(exp_bus_q.size()), 64'd0);
        chk("read_script_drained", 64'(rd_data_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/perf_cnt_master.md
# perf_cnt_master

Avalon-MM master that drives the system performance-counter peripheral from hardware. Accelerator logic can start, stop and clear timing sections and read back a section's 64-bit time and 32-bit event counts without involving the CPU. It sits between an accelerator-side command port and the perf-counter control slave, through the system interconnect. Time reads use a high/low/high sequence so a running counter never returns a torn value.

## Interface

Parameters:
- MAX_RETRY, 3: extra low/high re-read attempts before a time read is flagged torn.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted on the cycle where cmd_valid & cmd_ready
- cmd_op  in  2  0=GO, 1=STOP, 2=CLEAR_ALL, 3=READ
- cmd_section  in  3  section index s (0..7)
- cmd_done  out  1  one-cycle pulse when a command completes
- result_time  out  64  time counter of the last READ
- result_events  out  32  event counter of the last READ
- result_torn  out  1  last READ exhausted its retries
- avm_address  out  5  word address
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave stall
- avm_readdatavalid  in  1  read data valid

## Operation

- Address map for section s:
  - 4s: STOP on write; time[31:0] on read
  - 4s+1: GO on write; time[63:32] on read
  - 4s+2: events[31:0] on read
- Writes:
  - GO: write address 4s+1, data 0.
  - STOP: write address 4s, data 0.
  - CLEAR_ALL: write address 0, data 1. This clears every counter and stops section 0. cmd_section is ignored.
- Section 0 gates all other sections. The block passes commands through and does not enforce ordering.
- READ sequence, one outstanding read at a time:
  - RD_HI1 (4s+1) → RD_LO (4s) → RD_HI2 (4s+1).
  - If hi2 == hi1: result_time = {hi1, lo}; go to RD_EV (4s+2).
  - Else: hi1 := hi2, retry count +1, return to RD_LO.
  - After MAX_RETRY retries, still mismatched: result_time = {hi2, lo}, result_torn = 1, go to RD_EV.
- States: IDLE, WR, RD_HI1, RD_LO, RD_HI2, RD_EV, DONE. DONE pulses cmd_done and returns to IDLE.
- Avalon master rules:
  - avm_read/avm_write, avm_address and avm_writedata stay stable until a cycle with waitrequest low.
  - The request deasserts on the cycle after acceptance.
  - Read states wait for avm_readdatavalid before issuing the next request.
  - A readdatavalid outside a pending read is ignored.
  - avm_read and avm_write are never high together.
- Results: result_* update together in DONE, only for READ, and hold until the next READ completes. result_torn is cleared at the start of each READ.
- Commands arriving while busy are back-pressured via cmd_ready = 0 and are never dropped.

## Timing

- Reset values: cmd_ready=1 (IDLE); cmd_done, avm_read, avm_write, result_torn = 0; avm_address, avm_writedata, result_time, result_events = 0.
- Reset mid-transaction drops the transaction immediately. A readdatavalid arriving after reset deasserts is ignored.
- Write latency, command accepted at edge t, no wait states: avm_write high in cycle t+1; cmd_done at t+2; cmd_ready high at t+3.
- Each waitrequest cycle extends the write by one cycle.
- Read latency, no wait states, readdatavalid one cycle after acceptance, no retries:
  - reads issued at t+1, t+3, t+5, t+7
  - final data at t+8
  - cmd_done and result valid at t+9
- Each retry adds 4 cycles.
- Time arithmetic is a pure 64-bit concatenation; no addition or wrap handling.

## Test plan

- Reset, then GO on section 2 → one write with address 9, data 0; cmd_done two cycles after acceptance; no read strobes.
- CLEAR_ALL with cmd_section=5 → one write with address 0, data 1.
- Write stalled by waitrequest for 3 cycles → address and data held 4 cycles; write deasserts after acceptance; cmd_valid held during the write sees cmd_ready=0.
- READ section 1, slave returns hi=0x1, lo=0xFFFF_FFF0, hi=0x1, ev=7 → reads at addresses 5, 4, 5, 6; result_time=0x1_FFFF_FFF0, result_events=7, result_torn=0, cmd_done at t+9.
- READ section 0, slave returns hi 0x0, lo 0xFFFF_FFFF, hi 0x1, lo 0x2, hi 0x1 → one retry; result_time=0x1_0000_0002, result_torn=0.
- READ where high differs on every compare with MAX_RETRY=3 → 4 lo/hi pairs, result_torn=1.
- Assert reset while RD_LO waits for data → IDLE with all outputs at reset values; a subsequent READ completes normally.
